// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache.
// Line refill streams one word per beat from a word-wide memory port.
module icache_nway #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 16,
  parameter int WAYS       = 2,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [BUS_WIDTH-1:0]  addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_valid
);

  localparam int BOFF  = $clog2(DATA_WIDTH / 8);
  localparam int WOFF  = $clog2(LINE_WORDS);
  localparam int OFF   = BOFF + WOFF;
  localparam int IDX   = $clog2(SETS);
  localparam int TAGW  = BUS_WIDTH - OFF - IDX;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int DEPTH = WAYS * SETS * LINE_WORDS;
  localparam int AW    = WW + IDX + WOFF;

  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_REFILL, S_RESP
  } state_t;

  state_t                     r_state;
  logic [BUS_WIDTH-1:0]       r_addr;
  logic [WAYS-1:0][SETS-1:0]  r_valid;
  logic [SETS-1:0][WW-1:0]    r_rr;
  logic [WOFF-1:0]            r_beat;
  logic [WW-1:0]              r_victim;
  logic                       r_flush_pend;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic                       r_rdata_valid;
  logic                       r_mem_ce;
  logic [BUS_WIDTH-1:0]       r_mem_addr;
  logic [TAGW-1:0]            r_tag  [WAYS*SETS];
  logic [DATA_WIDTH-1:0]      r_data [DEPTH];

  logic [TAGW-1:0]       w_tag;
  logic [IDX-1:0]        w_idx;
  logic [WOFF-1:0]       w_woff;
  logic                  w_hit;
  logic [WW-1:0]         w_hit_way;
  logic                  w_inv;
  logic [WW-1:0]         w_inv_way;
  logic [WW-1:0]         w_victim;
  logic [AW-1:0]         w_rd_idx;
  logic [AW-1:0]         w_wr_idx;
  logic                  w_wr;
  logic                  w_last;
  logic [BUS_WIDTH-1:0]  w_line_addr;
  logic [BUS_WIDTH-1:0]  w_next_addr;
  logic                  w_unused;

  assign w_tag  = r_addr[BUS_WIDTH-1 -: TAGW];
  assign w_idx  = r_addr[OFF +: IDX];
  assign w_woff = r_addr[BOFF +: WOFF];

  assign w_last   = (r_beat == WOFF'(LINE_WORDS - 1));
  assign w_wr     = (r_state == S_REFILL) && mem_rdata_valid;
  assign w_rd_idx = {w_hit_way, w_idx, w_woff};
  assign w_wr_idx = {r_victim, w_idx, r_beat};
  assign w_victim = w_inv ? w_inv_way : r_rr[w_idx];

  assign w_line_addr =
    BUS_WIDTH'({w_tag, w_idx, {WOFF{1'b0}}}) << BOFF;
  assign w_next_addr =
    BUS_WIDTH'({w_tag, w_idx, r_beat + 1'b1}) << BOFF;

  assign w_unused = &{1'b0, r_addr};

  assign req_ready   = (r_state == S_IDLE) && !flush
                     && !r_flush_pend;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign mem_ce      = r_mem_ce;
  assign mem_we      = 1'b0;
  assign mem_addr    = r_mem_addr;

  // Tag match and lowest-index invalid way in the indexed set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_idx] &&
          r_tag[{WW'(w), w_idx}] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
      if (!r_valid[w][w_idx]) begin
        w_inv     = 1'b1;
        w_inv_way = WW'(w);
      end
    end
  end

  // Data and tag arrays; only valid bits gate hits
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[w_wr_idx] <= mem_rdata;
      if (w_last)
        r_tag[{r_victim, w_idx}] <= w_tag;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_valid       <= '0;
      r_rr          <= '0;
      r_beat        <= '0;
      r_victim      <= '0;
      r_flush_pend  <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_mem_ce      <= 1'b0;
      r_mem_addr    <= '0;
    end else begin
      if (r_state != S_IDLE && flush)
        r_flush_pend <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (flush || r_flush_pend) begin
            r_valid      <= '0;
            r_rr         <= '0;
            r_flush_pend <= 1'b0;
          end else if (ce) begin
            r_addr  <= addr;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_rdata       <= r_data[w_rd_idx];
            r_rdata_valid <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_victim <= w_victim;
            if (!w_inv && WAYS > 1)
              r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
            r_beat     <= '0;
            r_mem_ce   <= 1'b1;
            r_mem_addr <= w_line_addr;
            r_state    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_rdata_valid) begin
            if (r_beat == w_woff)
              r_rdata <= mem_rdata;
            if (w_last) begin
              r_valid[r_victim][w_idx] <= 1'b1;
              r_mem_ce      <= 1'b0;
              r_beat        <= '0;
              r_rdata_valid <= 1'b1;
              r_state       <= S_RESP;
            end else begin
              r_beat     <= r_beat + 1'b1;
              r_mem_addr <= w_next_addr;
            end
          end
        end
        S_RESP: begin
          if (rdata_ready) begin
            r_rdata_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 Parameter BUS_WIDTH, default 32: address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits; power of two, at least 8.
REQ-003 Parameter LINE_WORDS, default 16: words per line; power of two, at least 2.
REQ-004 Parameter WAYS, default 2: associativity; power of two, at least 1.
REQ-005 Parameter SETS, default 16: set count; power of two, at least 2.
REQ-006 Address split SHALL be: OFF = log2(LINE_WORDS*DATA_WIDTH/8) low bits; next IDX = log2(SETS) bits; TAG = BUS_WIDTH-OFF-IDX upper bits.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 ce  in  1  CPU fetch request valid.
REQ-010 addr  in  BUS_WIDTH  fetch byte address; low log2(DATA_WIDTH/8) bits are ignored.
REQ-011 req_ready  out  1  request accepted when ce and req_ready are both high.
REQ-012 flush  in  1  single-cycle pulse that invalidates all lines.
REQ-013 rdata  out  DATA_WIDTH  fetched word.
REQ-014 rdata_valid  out  1  rdata is valid.
REQ-015 rdata_ready  in  1  CPU consumes rdata.
REQ-016 mem_ce  out  1  refill word request.
REQ-017 mem_we  out  1  tied to 0; the cache is read-only.
REQ-018 mem_addr  out  BUS_WIDTH  refill word address.
REQ-019 mem_rdata  in  DATA_WIDTH  refill data.
REQ-020 mem_rdata_valid  in  1  mem_rdata valid for the current mem_addr.

Function
REQ-021 States SHALL be IDLE, LOOKUP, REFILL and RESP.
REQ-022 req_ready SHALL equal (state==IDLE) && !flush && !flush_pending.
REQ-023 IDLE: on an accepted request, latch addr and go to LOOKUP.
REQ-024 LOOKUP: compare the latched TAG against all valid ways of the indexed set; on a hit, latch the word into rdata and go to RESP; on a miss, select a victim and go to REFILL.
REQ-025 Hit latency: acceptance edge N; rdata_valid is high from cycle N+2.
REQ-026 Victim selection: the lowest-index invalid way; if every way is valid, the way given by the per-set round-robin pointer, which then advances by 1 modulo WAYS.
REQ-027 REFILL: mem_ce=1; mem_addr = {tag, idx, beat, zero byte offset}.
REQ-028 REFILL beat counter: beat starts at 0 and increments on each mem_rdata_valid; each beat writes mem_rdata into the victim way.
REQ-029 REFILL capture: when beat equals the requested word offset, mem_rdata is also captured into rdata.
REQ-030 REFILL exit: on the beat LINE_WORDS-1 with mem_rdata_valid, write the tag, set the valid bit, drop mem_ce on the next cycle, and go to RESP.
REQ-031 No line in the cache SHALL be valid until its final beat has been written.
REQ-032 RESP: rdata_valid=1 and rdata held stable until rdata_ready=1, then go to IDLE; rdata_valid is low in every other state.
REQ-033 Flush in IDLE clears all valid bits and round-robin pointers on that edge; a ce in the same cycle is not accepted.
REQ-034 Flush in any other state sets flush_pending; the flush is applied on the first IDLE cycle, and the in-flight access completes normally.
REQ-035 mem_rdata_valid outside REFILL SHALL be ignored.

Reset
REQ-036 On reset=0, and immediately regardless of clk: state=IDLE; all valid bits, round-robin pointers, beat counter and flush_pending cleared; mem_ce=0; rdata_valid=0; rdata=0; mem_addr=0.
REQ-037 Reset asserted mid-refill SHALL abandon the refill, leave no partial line valid, and deassert mem_ce asynchronously.
REQ-038 Data arrays need no reset; only the valid bits gate hits.

Verification (defaults: OFF=6, IDX=addr[9:6], TAG=addr[31:10])
REQ-039 Cold miss at 0x1000_0004 -> 16 mem_ce beats at addresses 0x1000_0000..0x1000_003C; rdata = beat-1 data.
REQ-040 Re-fetch of 0x1000_0008 after the cold miss -> hit: rdata_valid two cycles after acceptance, with no mem_ce.
REQ-041 Fetch 0x0000_0000, 0x0000_0400, then 0x0000_0800 (all set 0) -> 0x800 evicts way 0; a subsequent fetch of 0x400 hits and a fetch of 0x000 misses.
REQ-042 rdata_ready held at 0 for 5 cycles in RESP -> rdata_valid=1 and rdata stable throughout, req_ready=0; returns to IDLE one cycle after rdata_ready=1.
REQ-043 Flush pulse during REFILL -> the current fetch returns correct data; a re-fetch of the same address then misses.
REQ-044 reset=0 at beat 7 of a refill -> mem_ce=0 immediately; after reset release, a fetch of the same address misses and refills all 16 beats.
